// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with increment, jump, a call/return
// stack and RUN/HALTED control. The current PC addresses instruction
// memory; jump/call targets come from the reg8 stage Q output.
//
// Optional build macro: PC_WRAP_TRAP_EN
//   defined   - an inc at PC=all-ones holds the PC, sets wrap_trap and halts.
//   undefined - inc wraps modulo 2^WIDTH and wrap_trap stays 0.
//
// Handshake note: every command input is a level sampled on the rising clk
// edge; there is no ready/backpressure. Each command acts in the cycle it is
// sampled, and its result appears on the registered outputs one cycle later.
module pc_seq #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic             resume,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
  output logic             wrap_trap
);

  // Stack pointer needs one extra bit so that "full" (sp==DEPTH) is encodable.
  localparam int IDXW = $clog2(DEPTH);
  localparam int SPW  = IDXW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [0:0]       state_q, state_d;
  logic             err_q, err_d;
  logic             trap_q, trap_d;
  logic             push_en;
  logic [WIDTH-1:0] pc_inc;
  logic [IDXW-1:0]  top_idx;
  logic             full, empty;

  // Return-stack storage; contents are don't-care after reset.
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign pc_inc  = pc_q + WIDTH'(1);
  assign top_idx = IDXW'(sp_q - SPW'(1));
  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);

  // Next-state logic: halt > ret > call > jump > inc while running.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    state_d = state_q;
    err_d   = err_q;
    trap_d  = trap_q;
    push_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (ret) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SPW'(1);
          end
        end else if (call) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = target;
          end
        end else if (jump) begin
          pc_d = target;
        end else if (inc) begin
`ifdef PC_WRAP_TRAP_EN
          if (pc_q == '1) begin
            trap_d  = 1'b1;
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_inc;
          end
`else
          pc_d = pc_inc;
`endif
        end
      end
      default: begin
        // HALTED: everything holds until a resume without a concurrent halt.
        if (resume && !halt) state_d = ST_RUN;
      end
    endcase
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      state_q <= state_d;
      err_q   <= err_d;
      trap_q  <= trap_d;
    end
  end

  // Push the return address (PC+1, wrapping) into the next free slot.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[IDXW-1:0]] <= pc_inc;
  end

  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
  assign wrap_trap   = trap_q;

endmodule
